// File: rtl/spi_slave_tx_feeder.sv
// spi_slave_tx_feeder: word sequencer feeding the SPI slave transmit shifter.
// Pops 32-bit words from the read FIFO and loads them into the shifter one at
// a time. It also programs the shifter bit counter (31 for single mode, 7 for
// quad mode). On an empty FIFO it substitutes a zero word and sets a sticky
// underrun flag.
//
// Handshakes: a FIFO pop happens in any cycle where fifo_valid and fifo_ready
// are both high. fifo_ready is only ever raised in an issue cycle, and only
// when fifo_valid is already high, so read data must be valid in the pop cycle.
// The shifter sees tx_data_valid and tx_counter_upd as single-cycle load
// strobes. It answers with tx_done in the cycle that ends each word.
module spi_slave_tx_feeder #(
    parameter int LEN_W = 16
) (
    input  logic             sclk,
    input  logic             cs,
    input  logic             tx_start,
    input  logic [LEN_W-1:0] tx_len,
    input  logic             en_quad,
    input  logic [31:0]      fifo_data,
    input  logic             fifo_valid,
    output logic             fifo_ready,
    output logic [31:0]      tx_data,
    output logic             tx_data_valid,
    output logic [7:0]       tx_counter,
    output logic             tx_counter_upd,
    input  logic             tx_done,
    output logic             busy,
    output logic [LEN_W-1:0] words_left,
    output logic             xfer_done,
    output logic             underrun,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    localparam logic [LEN_W-1:0] LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_words_left;
    logic             r_quad;
    logic             r_xfer_done;
    logic             r_underrun;

    logic             w_start_ok;
    logic             w_issue;
    logic             w_final;

    // A start is accepted only from IDLE, and only with a non-zero length.
    assign w_start_ok = (r_state == S_IDLE) && tx_start && (tx_len != LEN_ZERO);

    // Issue: LOAD always issues, ACTIVE issues on tx_done. cs suppresses it.
    assign w_issue = !cs && ((r_state == S_LOAD) ||
                             ((r_state == S_ACTIVE) && tx_done));

    // The last word has finished shifting out.
    assign w_final = !cs && (r_state == S_DRAIN) && tx_done;

    assign tx_data_valid  = w_issue;
    assign tx_counter_upd = w_issue;
    assign fifo_ready     = w_issue && fifo_valid;
    assign tx_data        = (w_issue && fifo_valid) ? fifo_data : 32'h0;
    assign tx_counter     = r_quad ? 8'd7 : 8'd31;
    assign busy           = (r_state != S_IDLE);
    assign words_left     = r_words_left;
    assign xfer_done      = r_xfer_done;
    assign underrun       = r_underrun;
    assign dbg_state      = r_state;

    // Next-state selection for the IDLE/LOAD/ACTIVE/DRAIN sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                w_next_state = (r_len > LEN_ONE) ? S_ACTIVE : S_DRAIN;
            end
            S_ACTIVE: begin
                if (tx_done && (r_words_left == LEN_ONE)) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (tx_done) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register and end-of-transfer pulse; cs forces IDLE with no pulse.
    always_ff @(posedge sclk) begin
        if (cs) begin
            r_state     <= S_IDLE;
            r_xfer_done <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_xfer_done <= w_final;
        end
    end

    // Transfer parameters, latched when a start is accepted.
    always_ff @(posedge sclk) begin
        if (cs) begin
            r_len  <= LEN_ZERO;
            r_quad <= 1'b0;
        end else if (w_start_ok) begin
            r_len  <= tx_len;
            r_quad <= en_quad;
        end
    end

    // Remaining-word counter: loaded in LOAD, counts down on issues, never wraps.
    always_ff @(posedge sclk) begin
        if (cs) begin
            r_words_left <= LEN_ZERO;
        end else if (r_state == S_LOAD) begin
            r_words_left <= r_len - LEN_ONE;
        end else if (w_issue && (r_words_left != LEN_ZERO)) begin
            r_words_left <= r_words_left - LEN_ONE;
        end
    end

    // Sticky underrun flag: set when a zero word is inserted, cleared on start.
    always_ff @(posedge sclk) begin
        if (cs) begin
            r_underrun <= 1'b0;
        end else if (w_start_ok) begin
            r_underrun <= 1'b0;
        end else if (w_issue && !fifo_valid) begin
            r_underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_slave_tx_feeder.sv
// Testbench for spi_slave_tx_feeder: directed scenarios plus randomized
// transfers, checked cycle by cycle against a transfer-level reference model.
module tb_spi_slave_tx_feeder;
  localparam int LEN_W = 16;

  // clock / reset block
  logic             sclk = 1'b0;
  logic             cs;
  logic             tx_start;
  logic [LEN_W-1:0] tx_len;
  logic             en_quad;
  logic [31:0]      fifo_data;
  logic             fifo_valid;
  logic             fifo_ready;
  logic [31:0]      tx_data;
  logic             tx_data_valid;
  logic [7:0]       tx_counter;
  logic             tx_counter_upd;
  logic             tx_done;
  logic             busy;
  logic [LEN_W-1:0] words_left;
  logic             xfer_done;
  logic             underrun;
  logic [1:0]       dbg_state;

  always #5 sclk = ~sclk;

  spi_slave_tx_feeder #(.LEN_W(LEN_W)) dut (
    .sclk           (sclk),
    .cs             (cs),
    .tx_start       (tx_start),
    .tx_len         (tx_len),
    .en_quad        (en_quad),
    .fifo_data      (fifo_data),
    .fifo_valid     (fifo_valid),
    .fifo_ready     (fifo_ready),
    .tx_data        (tx_data),
    .tx_data_valid  (tx_data_valid),
    .tx_counter     (tx_counter),
    .tx_counter_upd (tx_counter_upd),
    .tx_done        (tx_done),
    .busy           (busy),
    .words_left     (words_left),
    .xfer_done      (xfer_done),
    .underrun       (underrun),
    .dbg_state      (dbg_state)
  );

  // FIFO feeding the DUT: the bench pushes, the DUT pops.
  logic [31:0] fifo_mem [0:15];
  int          wr_ptr  = 0;
  int          rd_ptr  = 0;
  int          pop_cnt = 0;

  assign fifo_valid = (wr_ptr != rd_ptr);
  assign fifo_data  = fifo_mem[rd_ptr[3:0]];

  always @(posedge sclk) begin
    if (fifo_ready && fifo_valid) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  // scoreboard: words expected out of the FIFO, plus expected registered outputs
  logic [31:0]      exp_q[$];
  int               exp_pops = 0;
  logic             g_busy;
  logic             g_xd;
  logic             g_ur;
  logic [LEN_W-1:0] g_wl;
  logic [7:0]       g_cnt;
  int               total = 0;
  int               bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  task automatic set_reset_model();
    g_busy = 1'b0;
    g_xd   = 1'b0;
    g_ur   = 1'b0;
    g_wl   = '0;
    g_cnt  = 8'd31;
  endtask

  // Checks every output in the current cycle. iss says whether this cycle
  // must hand a word to the shifter. The model's FIFO state decides the word.
  task automatic check_cycle(input bit iss, input string where);
    bit          avail;
    logic [31:0] w;
    avail = (exp_q.size() > 0);
    w     = avail ? exp_q[0] : 32'h0;
    chk({where, ":tx_data_valid"},  {31'h0, tx_data_valid},  {31'h0, iss});
    chk({where, ":tx_counter_upd"}, {31'h0, tx_counter_upd}, {31'h0, iss});
    chk({where, ":fifo_ready"},     {31'h0, fifo_ready},     {31'h0, iss && avail});
    chk({where, ":tx_data"},        tx_data,                 iss ? w : 32'h0);
    chk({where, ":busy"},           {31'h0, busy},           {31'h0, g_busy});
    chk({where, ":words_left"},     {16'h0, words_left},     {16'h0, g_wl});
    chk({where, ":xfer_done"},      {31'h0, xfer_done},      {31'h0, g_xd});
    chk({where, ":underrun"},       {31'h0, underrun},       {31'h0, g_ur});
    chk({where, ":tx_counter"},     {24'h0, tx_counter},     {24'h0, g_cnt});
    chk({where, ":pop_count"},      pop_cnt,                 exp_pops);
    if (iss) begin
      if (avail) begin
        void'(exp_q.pop_front());
        exp_pops++;
      end else begin
        g_ur = 1'b1;
      end
    end
  endtask

  // driver: hold cs for n cycles
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sclk);
      cs = 1'b1; tx_start = 1'b0; tx_done = 1'b0;
      #1;
      if (i > 0) check_cycle(1'b0, "reset");
      set_reset_model();
    end
  endtask

  // driver: idle cycles, optionally with zero-length start requests and stray tx_done
  task automatic idle(input int n, input bit zero_start);
    for (int i = 0; i < n; i++) begin
      @(negedge sclk);
      cs = 1'b0; tx_start = zero_start; tx_len = '0;
      en_quad = 1'($urandom_range(0, 1));
      tx_done = 1'($urandom_range(0, 1));
      #1;
      check_cycle(1'b0, zero_start ? "zero_len" : "idle");
      g_xd   = 1'b0;
      g_busy = 1'b0;
    end
  endtask

  // driver: one transfer. The shifter model raises tx_done `period` cycles after
  // each load. restart_cyc injects a tx_start while busy. abort_cyc raises cs,
  // and collide also raises tx_done in that same cycle.
  task automatic xfer(input int len, input bit quad, input int period,
                      input int restart_cyc, input int abort_cyc, input bit collide);
    int c;
    int issued;
    int dones;
    int since;
    bit fin;
    bit iss;
    bit dn;
    bit ab;
    @(negedge sclk);
    cs = 1'b0; tx_done = 1'b0; tx_start = 1'b1;
    tx_len = LEN_W'(len); en_quad = quad;
    #1;
    check_cycle(1'b0, "start");
    g_xd = 1'b0; g_busy = 1'b1; g_ur = 1'b0;
    g_cnt = quad ? 8'd7 : 8'd31;
    c = 0; issued = 0; dones = 0; since = 0; fin = 1'b0;
    while (!fin && c < 2000) begin
      c++;
      @(negedge sclk);
      tx_start = 1'b0; tx_done = 1'b0; cs = 1'b0;
      ab = (c == abort_cyc);
      dn = 1'b0;
      if (issued > 0) since++;
      if (ab) begin
        cs = 1'b1;
        tx_done = collide;
      end else if (issued > 0 && since == period) begin
        tx_done = 1'b1;
        dn = 1'b1;
      end
      if (c == restart_cyc) begin
        tx_start = 1'b1;
        tx_len   = LEN_W'($urandom_range(1, 5));
        en_quad  = !quad;
      end
      #1;
      iss = !ab && ((c == 1) || (dn && (dones + 1 < len)));
      check_cycle(iss, ab ? "abort" : "xfer");
      if (ab) begin
        set_reset_model();
        fin = 1'b1;
      end else begin
        if (iss) begin
          issued++;
          since = 0;
          g_wl = LEN_W'(len - issued);
        end
        if (dn) begin
          dones++;
          if (dones == len) begin
            fin    = 1'b1;
            g_busy = 1'b0;
            g_xd   = 1'b1;
          end
        end
      end
    end
    chk("xfer_finished", {31'h0, fin}, 32'h1);
  endtask

  initial begin
    int len;
    int nw;
    cs = 1'b1; tx_start = 1'b0; tx_len = '0; en_quad = 1'b0; tx_done = 1'b0;
    set_reset_model();
    do_reset(3);

    // single mode, 3 words, tx_done every 32 cycles
    push_word(32'hA5A5A5A5);
    push_word(32'h12345678);
    push_word(32'hDEADBEEF);
    xfer(3, 1'b0, 32, -1, -1, 1'b0);
    idle(2, 1'b0);

    // quad mode, 1 word: LOAD straight to DRAIN
    push_word(32'hCAFEF00D);
    xfer(1, 1'b1, 5, -1, -1, 1'b0);
    idle(1, 1'b0);

    // underrun: 2 words requested, 1 available; flag stays until next start
    push_word($urandom);
    xfer(2, 1'b0, 4, -1, -1, 1'b0);
    idle(3, 1'b0);
    push_word($urandom);
    xfer(1, 1'b0, 3, -1, -1, 1'b0);
    idle(1, 1'b0);

    // zero-length request, then a restart attempt mid-transfer
    idle(3, 1'b1);
    for (int i = 0; i < 4; i++) push_word($urandom);
    xfer(4, 1'b0, 6, 9, -1, 1'b0);

    // back-to-back: next start lands in the xfer_done cycle
    push_word($urandom);
    push_word($urandom);
    xfer(2, 1'b1, 3, -1, -1, 1'b0);
    idle(1, 1'b0);

    // cs during the 2nd word of a 4-word transfer, then a normal transfer
    for (int i = 0; i < 4; i++) push_word($urandom);
    xfer(4, 1'b0, 10, -1, 15, 1'b0);
    idle(2, 1'b0);
    xfer(2, 1'b0, 4, -1, -1, 1'b0);
    idle(1, 1'b0);

    // tx_done and cs together
    for (int i = 0; i < 3; i++) push_word($urandom);
    xfer(3, 1'b0, 5, -1, 6, 1'b1);
    idle(1, 1'b0);
    xfer(2, 1'b1, 2, -1, -1, 1'b0);

    // randomized transfers, with random FIFO fill levels (underruns included)
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 6);
      nw  = $urandom_range(0, len);
      for (int i = 0; i < nw; i++) push_word($urandom);
      xfer(len, 1'($urandom_range(0, 1)), $urandom_range(1, 6), -1, -1, 1'b0);
      idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    idle(2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_tx_feeder.md
# spi_slave_tx_feeder

Word sequencer that sits directly upstream of the SPI slave transmit shifter, in the `sclk` domain. It pops 32-bit read words from the read-side FIFO and hands them to the shifter one at a time. For each word it programs the shifter's bit counter: 32 bits in single mode, 8 nibbles in quad mode. Words are issued back-to-back on the shifter's `done` pulse. If the FIFO is empty when a word is needed, the block inserts a zero word and records the underrun.

## Interface

Parameters:

- `LEN_W`, default 16: width of the word-length field and of the remaining-word counter.

Ports, listed as name, direction, width, meaning:

- `sclk`, in, 1: the block's only clock. All state updates on the rising edge.
- `cs`, in, 1: reset. Synchronous, active-high, sampled on `sclk`. While high, all state returns to reset values.
- `tx_start`, in, 1: one-cycle request to start a transfer.
  - Sampled only in the IDLE state.
- `tx_len`, in, `LEN_W`: number of 32-bit words in the transfer. Sampled together with `tx_start`.
- `en_quad`, in, 1: quad mode select. Sampled together with `tx_start`.
- `fifo_data`, in, 32: read word from the FIFO.
- `fifo_valid`, in, 1: FIFO is non-empty.
- `fifo_ready`, out, 1: pop strobe. A pop occurs when `fifo_valid` and `fifo_ready` are both high.
- `tx_data`, out, 32: word passed to the shifter.
- `tx_data_valid`, out, 1: load strobe for the shifter.
- `tx_counter`, out, 8: bit-counter target for the shifter.
- `tx_counter_upd`, out, 1: counter-update strobe for the shifter.
- `tx_done`, in, 1: the shifter's last-bit indication.
- `busy`, out, 1: high in any state other than IDLE.
- `words_left`, out, `LEN_W`: number of words not yet issued.
- `xfer_done`, out, 1: one-cycle pulse after the last word completes.
- `underrun`, out, 1: sticky flag. Set when a zero word was inserted. Cleared by `cs` or by an accepted `tx_start`.

## Operation

The state machine has four states: IDLE, LOAD, ACTIVE and DRAIN. An "issue" is the action of handing one word to the shifter.

- **Target value**
  - The target is registered `quad_q ? 8'd7 : 8'd31`.
  - `quad_q` is latched from `en_quad` when `tx_start` is accepted.
  - `tx_counter` drives the target value at all times.
- **Issue (combinational, during the issue cycle)**
  - `tx_data_valid` = 1 and `tx_counter_upd` = 1.
  - `fifo_ready` = `fifo_valid`.
  - `tx_data` = `fifo_valid ? fifo_data : 32'h0`.
  - If `fifo_valid` = 0, `underrun` is set at the next edge.
- **Outside an issue cycle:** `tx_data_valid`, `tx_counter_upd` and `fifo_ready` are 0, and `tx_data` is 0.
- **IDLE**
  - If `tx_start` = 1 and `tx_len` != 0, the block latches `tx_len` and `en_quad`, clears `underrun`, and goes to LOAD.
  - If `tx_start` = 1 and `tx_len` = 0, the request is ignored: the state stays IDLE and `xfer_done` is not pulsed.
- **LOAD**
  - The block always issues a word.
  - `words_left` ← latched length − 1.
  - Next state is ACTIVE if the latched length > 1, otherwise DRAIN.
- **ACTIVE**
  - When `tx_done` = 1, the block issues a word in that same cycle and decrements `words_left`.
  - It goes to DRAIN when `words_left` is 1 before the decrement.
  - When `tx_done` = 0, the block holds.
- **DRAIN**
  - When `tx_done` = 1, the block goes to IDLE and pulses `xfer_done` in the next cycle.
  - No issue takes place.
- **`tx_start` while busy:** ignored, with no effect on any state.
- **`tx_done` in IDLE or LOAD:** ignored.
- **`words_left` arithmetic:** unsigned and never wraps. A decrement happens only on an issue while `words_left` > 0.
- **`cs` high in any state, mid-word or mid-transfer**
  - The next edge forces IDLE.
  - FIFO contents are not touched beyond pops already made.
  - No `xfer_done` pulse is generated.

## Timing

- **Reset values**
  - State: IDLE.
  - `fifo_ready` 0, `tx_data` 0, `tx_data_valid` 0, `tx_counter_upd` 0.
  - `tx_counter` 31 (`quad_q` = 0).
  - `busy` 0, `words_left` 0, `xfer_done` 0, `underrun` 0.
- **Start latency:** if `tx_start` is accepted in cycle n, the first issue occurs in cycle n+1, with `busy` = 1 from n+1.
- **Subsequent issues:** each occurs in the same cycle as the `tx_done` that ends the previous word, with zero bubble.
- **`fifo_ready`** is combinational from state, `tx_done` and `fifo_valid`. There is no registered lookahead, so FIFO read data must be valid in the same cycle as the pop.
- **End of transfer:** `xfer_done` pulses in the cycle after DRAIN sees `tx_done`. `busy` falls in that same cycle.
- **Same-cycle `tx_done` and `cs`:** `cs` wins. There is no issue and no pop.
- **Minimum gap between transfers:** the next `tx_start` can be accepted in the `xfer_done` cycle.

## Test plan

- **Single mode, 3 words.** Stimulus: `tx_start`, `tx_len` = 3, `en_quad` = 0, FIFO holding A5A5A5A5, 12345678 and DEADBEEF, bench pulsing `tx_done` every 32 cycles. Required response:
  - Three issues with `tx_counter` = 31, in order, each coinciding with a `tx_done` except the first.
  - Pops exactly aligned with the issues.
  - `xfer_done` one cycle after the 3rd `tx_done`.
  - `underrun` = 0.
- **Quad mode, 1 word.** Stimulus: `tx_len` = 1, `en_quad` = 1, FIFO holding CAFEF00D. Required response:
  - LOAD goes directly to DRAIN.
  - `tx_counter` = 7.
  - `xfer_done` one cycle after the first `tx_done`.
  - `words_left` reads 0 from the cycle after the issue.
- **Underrun.** Stimulus: `tx_len` = 2, FIFO holding 1 word. Required response:
  - The second issue has `tx_data` = 0 and `fifo_ready` = 0.
  - `underrun` = 1 until the next `tx_start`, then 0.
- **Zero length and busy restart.** Stimulus: `tx_start` with `tx_len` = 0, then a second `tx_start` during an ACTIVE transfer. Required response:
  - For the zero-length request: no issue, `busy` stays 0, no `xfer_done`.
  - For the mid-transfer request: `words_left` and the word stream are unchanged.
- **Reset mid-transfer.** Stimulus: `cs` high for 1 cycle during the 2nd word of a 4-word transfer. Required response:
  - All outputs return to their reset values.
  - Only 2 pops recorded.
  - No `xfer_done`.
  - A subsequent `tx_start` works normally.
- **Collision.** Stimulus: `tx_done` and `cs` asserted in the same cycle. Required response: no issue and no pop in that cycle, and IDLE at the next edge.
